uart_tx_queue: RTL and testbench

//  Byte FIFO plus launch sequencer between game-side message producers and uart_tx.

---
 rtl/uart_tx_queue.sv | 152 +++++++++++++++
 tb/tb_uart_tx_queue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding uart_tx through a launch sequencer.
// Game-side producers push bytes at any time. Bytes are launched one at a time,
// each after uart_tx has returned to idle, so nothing is skipped while the
// transmitter is busy.
module uart_tx_queue #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     flush,
  input  logic                     clear_overflow,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level_next;
  logic            pop;
  logic            push;
  logic            drop;

  // The head is popped in the same cycle that tx_start is raised.
  assign pop  = (state == IDLE) && !empty && !tx_busy;
  // A full queue still accepts a push when a pop frees a slot in the same cycle.
  // flush discards a simultaneous push without counting it as a drop.
  assign push = wr_en && !flush && (!full || pop);
  assign drop = wr_en && !flush && full && !pop;

  // Next occupancy, shared by level/full/empty so all three stay consistent.
  always_comb begin
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else begin
      level_next = level + LW'(push) - LW'(pop);
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Circular pointers and registered occupancy flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
      level <= level_next;
      full  <= (level_next == LW'(DEPTH));
      empty <= (level_next == '0);
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a same-cycle clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= 8'h00;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_overflow) begin
        drop_count <= 8'h01;
      end else if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'h01;
      end
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= 8'h00;
    end
  end

  // Launch sequencer: pop and pulse, wait for busy to rise (or time out), wait for busy to fall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= mem[rd_ptr];
            tx_start <= 1'b1;
            timer    <= '0;
            state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
            state <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a simple uart_tx busy model.
module tb_uart_tx_queue;

  localparam int unsigned DEPTH        = 16;
  localparam int unsigned BUSY_TIMEOUT = 8;
  localparam int          BUSY_CYC     = 10;

  logic       clock;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       clear_overflow;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic [7:0] drop_count;

  int checks   = 0;
  int failures = 0;

  // Busy model / forced busy selection.
  logic busy_auto;
  logic busy_force;
  logic model_busy;
  int   model_cnt;
  assign tx_busy = busy_auto ? model_busy : busy_force;

  // Monitor state.
  int         cyc     = 0;
  int         n_start = 0;
  int         viol    = 0;
  logic       prev_start = 1'b0;
  logic [7:0] last_data  = 8'h00;
  logic [7:0] got_data[$];
  int         got_cyc[$];

  uart_tx_queue #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clock          (clock),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .flush          (flush),
    .clear_overflow (clear_overflow),
    .tx_busy        (tx_busy),
    .tx_start       (tx_start),
    .tx_data        (tx_data),
    .full           (full),
    .empty          (empty),
    .level          (level),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // uart_tx stand-in: busy for BUSY_CYC clocks starting the edge after tx_start.
  initial begin
    model_busy = 1'b0;
    model_cnt  = 0;
  end
  always @(posedge clock) begin
    if (tx_start) begin
      model_cnt  <= BUSY_CYC;
      model_busy <= 1'b1;
    end else if (model_cnt > 1) begin
      model_cnt <= model_cnt - 1;
    end else if (model_cnt == 1) begin
      model_cnt  <= 0;
      model_busy <= 1'b0;
    end
  end

  // Records launches and protocol violations (start while busy, double pulse, data change while busy).
  always @(negedge clock) begin
    if (reset) begin
      last_data = 8'h00;
    end else if (tx_start) begin
      if (tx_busy) viol++;
      if (prev_start) viol++;
      got_data.push_back(tx_data);
      got_cyc.push_back(cyc);
      n_start++;
      last_data = tx_data;
    end else if (tx_busy && tx_data !== last_data) begin
      viol++;
    end
    prev_start = tx_start;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clock);
    wr_en   = 1'b0;
  endtask

  task automatic clear_log();
    got_data.delete();
    got_cyc.delete();
  endtask

  function automatic logic [31:0] data_at(input int i);
    if (i < got_data.size()) return 32'(got_data[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] gap_at(input int i);
    if (i + 1 < got_cyc.size()) return 32'(got_cyc[i+1] - got_cyc[i]);
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    int n0;
    logic [7:0] burst [4];
    burst[0] = 8'h30; burst[1] = 8'h31; burst[2] = 8'h32; burst[3] = 8'h52;

    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    clear_overflow = 1'b0; busy_auto = 1'b0; busy_force = 1'b0;
    repeat (3) @(negedge clock);

    // Reset values
    chk("rst_tx_start",   32'(tx_start),   0);
    chk("rst_tx_data",    32'(tx_data),    0);
    chk("rst_full",       32'(full),       0);
    chk("rst_empty",      32'(empty),      1);
    chk("rst_level",      32'(level),      0);
    chk("rst_overflow",   32'(overflow),   0);
    chk("rst_drop_count", 32'(drop_count), 0);
    reset = 1'b0;
    @(negedge clock);

    // T1: reset while in WAIT_DONE
    busy_auto = 1'b1;
    push(8'h41);
    @(negedge clock);
    chk("t1_start",  32'(tx_start), 1);
    chk("t1_data",   32'(tx_data),  32'h41);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("t1_rst_start", 32'(tx_start), 0);
    chk("t1_rst_empty", 32'(empty),    1);
    chk("t1_rst_level", 32'(level),    0);
    reset = 1'b0;
    n0 = n_start;
    repeat (25) @(negedge clock);
    chk("t1_no_start", 32'(n_start - n0), 0);

    // T2: single byte latency
    n0 = n_start;
    push(8'h33);
    chk("t2_not_yet", 32'(tx_start), 0);
    @(negedge clock);
    chk("t2_start", 32'(tx_start), 1);
    chk("t2_data",  32'(tx_data),  32'h33);
    repeat (25) @(negedge clock);
    chk("t2_one_pulse", 32'(n_start - n0), 1);
    chk("t2_data_held", 32'(tx_data), 32'h33);

    // T3: burst of four with 10-clock busy per byte
    clear_log();
    for (int i = 0; i < 4; i++) push(burst[i]);
    repeat (70) @(negedge clock);
    chk("t3_count", 32'(got_data.size()), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_data%0d", i), data_at(i), 32'(burst[i]));
    for (int i = 0; i < 3; i++) chk($sformatf("t3_gap%0d", i), gap_at(i), 13);

    // T4: overflow with busy held high
    busy_auto = 1'b0; busy_force = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) push(8'(8'h60 + i));
    chk("t4_full",     32'(full),       1);
    chk("t4_level",    32'(level),      DEPTH);
    chk("t4_empty",    32'(empty),      0);
    chk("t4_overflow", 32'(overflow),   1);
    chk("t4_drops",    32'(drop_count), 3);
    // drop and clear in the same cycle: drop wins
    wr_en = 1'b1; wr_data = 8'hEE; clear_overflow = 1'b1;
    @(negedge clock);
    wr_en = 1'b0; clear_overflow = 1'b0;
    chk("t4_drop_wins_ovf", 32'(overflow),   1);
    chk("t4_drop_wins_cnt", 32'(drop_count), 1);
    chk("t4_level_kept",    32'(level),      DEPTH);
    clear_overflow = 1'b1;
    @(negedge clock);
    clear_overflow = 1'b0;
    chk("t4_clr_ovf", 32'(overflow),   0);
    chk("t4_clr_cnt", 32'(drop_count), 0);
    clear_log();
    busy_auto = 1'b1;
    repeat (DEPTH * 13 + 20) @(negedge clock);
    chk("t4_count", 32'(got_data.size()), DEPTH);
    for (int i = 0; i < DEPTH; i++) chk($sformatf("t4_data%0d", i), data_at(i), 32'(8'h60 + i));
    chk("t4_empty_after", 32'(empty), 1);

    // T5: full queue, push on the pop cycle
    busy_auto = 1'b0; busy_force = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(8'(8'h80 + i));
    chk("t5_full", 32'(full), 1);
    clear_log();
    busy_force = 1'b0; wr_en = 1'b1; wr_data = 8'h58;
    @(negedge clock);
    wr_en = 1'b0; busy_auto = 1'b1;
    chk("t5_start", 32'(tx_start),   1);
    chk("t5_head",  32'(tx_data),    32'h80);
    chk("t5_level", 32'(level),      DEPTH);
    chk("t5_full2", 32'(full),       1);
    chk("t5_drops", 32'(drop_count), 0);
    repeat ((DEPTH + 1) * 13 + 20) @(negedge clock);
    chk("t5_count", 32'(got_data.size()), DEPTH + 1);
    for (int i = 0; i < DEPTH; i++) chk($sformatf("t5_data%0d", i), data_at(i), 32'(8'h80 + i));
    chk("t5_last", data_at(DEPTH), 32'h58);

    // T6: timeout spacing, then flush with simultaneous push
    busy_auto = 1'b0; busy_force = 1'b0;
    clear_log();
    push(8'h61);
    push(8'h62);
    repeat (30) @(negedge clock);
    chk("t6_count", 32'(got_data.size()), 2);
    chk("t6_data0", data_at(0), 32'h61);
    chk("t6_data1", data_at(1), 32'h62);
    chk("t6_gap",   gap_at(0),  BUSY_TIMEOUT + 1);
    busy_force = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(8'h70 + i));
    chk("t6_level5", 32'(level), 5);
    wr_en = 1'b1; wr_data = 8'h77; flush = 1'b1;
    @(negedge clock);
    wr_en = 1'b0; flush = 1'b0;
    chk("t6_flush_level", 32'(level),      0);
    chk("t6_flush_empty", 32'(empty),      1);
    chk("t6_flush_ovf",   32'(overflow),   0);
    chk("t6_flush_drops", 32'(drop_count), 0);
    n0 = n_start;
    busy_force = 1'b0;
    repeat (30) @(negedge clock);
    chk("t6_no_start", 32'(n_start - n0), 0);

    chk("protocol_violations", 32'(viol), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
